// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stop encoding,
// per-stage stall patterns and FSM state encodings.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. A request stops its
    // own stage and everything upstream of it.
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = {6{STOP}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_stall_mon.sv
// Saturating stall-cycle counter with synchronous clear (clear wins over
// increment).
module stall_mon #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: combinational stall vector from stage requests,
// data-memory wait FSM with timeout watchdog, and stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             cnt_clr,
    output logic [5:0]       stall,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;

    // ERR ignores the handshake entirely; the whole pipe is frozen instead.
    assign mem_stall = (state != ST_ERR) && mem_req && !mem_ack;

    // NOTE: the default assignment at the top of always_comb guarantees every
    // path drives stall, so no latch is inferred.
    always_comb begin
        stall = STALL_NONE;
        if (!rst_n)                stall = STALL_NONE;
        else if (state == ST_ERR)  stall = STALL_ALL;
        else if (mem_stall)        stall = STALL_MEM;
        else if (stallreq_ex)      stall = STALL_EX;
        else if (stallreq_id)      stall = STALL_ID;
        else if (stallreq_if)      stall = STALL_IF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    // Ack or withdrawal both end the access; ack beats timeout.
                    if (mem_ack || !mem_req) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state   <= ST_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    stall_mon #(
        .CNT_W (CNT_W)
    ) u_stall_mon (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall[0]),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             mem_req;
    logic             mem_ack;
    logic             cnt_clr;
    logic [5:0]       stall;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .cnt_clr      (cnt_clr),
        .stall        (stall),
        .bus_err      (bus_err),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: how many consecutive cycles the current memory access has
    // stalled, whether the watchdog has fired, and the saturating count.
    int  m_run;
    bit  m_err;
    int  m_cnt;
    logic [5:0] m_now;

    function automatic logic [5:0] model_stall();
        if (!rst_n)                return 6'b000000;
        if (m_err)                 return 6'b111111;
        if (mem_req && !mem_ack)   return 6'b011111;
        if (stallreq_ex)           return 6'b001111;
        if (stallreq_id)           return 6'b000111;
        if (stallreq_if)           return 6'b000011;
        return 6'b000000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0;
            m_err <= 1'b0;
            m_cnt <= 0;
        end else begin
            m_now = model_stall();
            if (!m_err) begin
                if (m_now == 6'b011111) begin
                    m_run <= m_run + 1;
                    if (m_run + 1 == TIMEOUT + 1) m_err <= 1'b1;
                end else begin
                    m_run <= 0;
                end
            end
            if (cnt_clr)       m_cnt <= 0;
            else if (m_now[0]) m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
    end

    always @(negedge clk) begin
        check("cmp_stall", 32'(stall), 32'(model_stall()));
        check("cmp_bus_err", 32'(bus_err), 32'(m_err));
        check("cmp_stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    end

    task automatic step(input bit f, input bit i, input bit e, input bit r, input bit a, input bit c);
        @(posedge clk);
        #1;
        stallreq_if = f;
        stallreq_id = i;
        stallreq_ex = e;
        mem_req     = r;
        mem_ack     = a;
        cnt_clr     = c;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0;
        mem_req = 0; mem_ack = 0; cnt_clr = 0;
        #2;
        check("rst_stall", 32'(stall), 32'h00);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_cnt", 32'(stall_cycles), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("idle_stall", 32'(stall), 32'h00);
        check("idle_cnt", 32'(stall_cycles), 32'h0);

        step(0, 1, 1, 0, 0, 0);
        check("id_ex_stall", 32'(stall), 32'b001111);
        step(0, 0, 0, 0, 0, 0);
        check("id_ex_cnt", 32'(stall_cycles), 32'd1);

        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 1, 0, 0);
            check("mem_wait_stall", 32'(stall), 32'b011111);
        end
        step(0, 1, 0, 1, 1, 0);
        check("ack_cycle_stall", 32'(stall), 32'b000111);
        step(0, 0, 0, 0, 0, 0);
        check("after_ack_stall", 32'(stall), 32'h00);
        check("after_ack_cnt", 32'(stall_cycles), 32'd5);

        step(0, 0, 0, 1, 1, 0);
        check("req_ack_idle", 32'(stall), 32'h00);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check("cnt_clr", 32'(stall_cycles), 32'd0);

        repeat (20) step(1, 0, 0, 0, 0, 0);
        check("if_stall", 32'(stall), 32'b000011);
        step(0, 0, 0, 0, 0, 0);
        check("cnt_sat", 32'(stall_cycles), 32'd15);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check("cnt_clr_prio", 32'(stall_cycles), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("cnt_after_clr", 32'(stall_cycles), 32'd1);

        repeat (TIMEOUT) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        check("ack_at_timeout", 32'(stall), 32'h00);
        step(0, 0, 0, 0, 0, 0);
        check("no_err_boundary", 32'(bus_err), 32'h0);

        repeat (2) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("withdraw_stall", 32'(stall), 32'b000111);
        step(0, 0, 0, 1, 0, 0);
        check("reentry_stall", 32'(stall), 32'b011111);
        step(0, 0, 0, 0, 0, 0);

        repeat (3) step(0, 0, 0, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_stall", 32'(stall), 32'h00);
        check("rst_mid_bus_err", 32'(bus_err), 32'h0);
        check("rst_mid_cnt", 32'(stall_cycles), 32'h0);
        mem_req = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_bus_err", 32'(bus_err), 32'h0);
        check("post_rst_cnt", 32'(stall_cycles), 32'h0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        check("post_rst_ack", 32'(stall), 32'h00);
        step(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < TIMEOUT + 1; k++) begin
            step(0, 0, 0, 1, 0, 0);
            check("to_wait_stall", 32'(stall), 32'b011111);
        end
        step(0, 0, 0, 1, 1, 0);
        check("err_stall", 32'(stall), 32'b111111);
        check("err_flag", 32'(bus_err), 32'h1);
        step(0, 0, 0, 0, 0, 0);
        check("err_persist", 32'(stall), 32'b111111);
        step(0, 0, 0, 0, 1, 1);
        check("err_ack_ignored", 32'(stall), 32'b111111);
        check("err_flag_sticky", 32'(bus_err), 32'h1);
        #1 rst_n = 1'b0;
        #1 check("err_rst_stall", 32'(stall), 32'h00);
        check("err_rst_bus_err", 32'(bus_err), 32'h0);
        cnt_clr = 0;
        mem_ack = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step(0, 0, 0, 0, 0, 0);
        check("final_idle", 32'(stall), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
